// File: rtl/cache_arbiter.sv
// Two-port arbiter sharing the SDRAM line cache device port between the CPU and the
// WOPI video fetcher: video priority with a CPU anti-starvation limit, plus an ack watchdog.
module cache_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int VID_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_write,
    input  logic              cpu_read_req,
    input  logic              cpu_write_req,
    output logic [DATA_W-1:0] cpu_data_read,
    output logic              cpu_read_ack,
    output logic              cpu_write_ack,
    input  logic [ADDR_W-1:0] vid_address,
    input  logic [DATA_W-1:0] vid_data_write,
    input  logic              vid_read_req,
    input  logic              vid_write_req,
    output logic [DATA_W-1:0] vid_data_read,
    output logic              vid_read_ack,
    output logic              vid_write_ack,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_data_write,
    output logic              cache_read_req,
    output logic              cache_write_req,
    input  logic [DATA_W-1:0] cache_data_read,
    input  logic              cache_read_ack,
    input  logic              cache_write_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_ISSUE   = 2'd1;
    localparam logic [1:0] ARB_WAIT    = 2'd2;
    localparam logic [1:0] ARB_RELEASE = 2'd3;

    localparam int SW = $clog2(VID_BURST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(VID_BURST);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_vid_q, owner_vid_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              cpu_rack_q, cpu_rack_d;
    logic              cpu_wack_q, cpu_wack_d;
    logic              vid_rack_q, vid_rack_d;
    logic              vid_wack_q, vid_wack_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [WW-1:0]     wd_q, wd_d;

    logic              cpu_pend, vid_pend, grant_vid, grant_cpu, done;
    logic [DATA_W-1:0] rdata_sel;

    assign cpu_pend  = cpu_read_req | cpu_write_req;
    assign vid_pend  = vid_read_req | vid_write_req;
    // Video wins ties until it has taken VID_BURST grants in a row over a waiting CPU.
    assign grant_vid = vid_pend & (~cpu_pend | (streak_q != STREAK_MAX));
    assign grant_cpu = cpu_pend & ~grant_vid;
    assign done      = op_write_q ? cache_write_ack : cache_read_ack;
    assign rdata_sel = done ? cache_data_read : {DATA_W{1'b1}};

    always_comb begin
        state_d     = state_q;
        owner_vid_d = owner_vid_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rack_d  = 1'b0;
        cpu_wack_d  = 1'b0;
        vid_rack_d  = 1'b0;
        vid_wack_d  = 1'b0;
        terr_d      = terr_q;
        streak_d    = streak_q;
        wd_d        = wd_q;

        case (state_q)
            ARB_IDLE: begin
                if (!cpu_pend) begin
                    streak_d = '0;
                end
                if (grant_vid) begin
                    owner_vid_d = 1'b1;
                    op_write_d  = vid_write_req;
                    addr_d      = vid_address;
                    wdata_d     = vid_data_write;
                    rd_req_d    = ~vid_write_req;
                    wr_req_d    = vid_write_req;
                    state_d     = ARB_ISSUE;
                    if (cpu_pend && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (grant_cpu) begin
                    owner_vid_d = 1'b0;
                    op_write_d  = cpu_write_req;
                    addr_d      = cpu_address;
                    wdata_d     = cpu_data_write;
                    rd_req_d    = ~cpu_write_req;
                    wr_req_d    = cpu_write_req;
                    state_d     = ARB_ISSUE;
                    streak_d    = '0;
                end
            end
            ARB_ISSUE: begin
                wd_d    = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // A matching ack on the watchdog's last cycle still counts as a normal completion.
                if (done || (wd_q == WD_LAST)) begin
                    cpu_rack_d = ~owner_vid_q & ~op_write_q;
                    cpu_wack_d = ~owner_vid_q &  op_write_q;
                    vid_rack_d =  owner_vid_q & ~op_write_q;
                    vid_wack_d =  owner_vid_q &  op_write_q;
                    if (!op_write_q) begin
                        if (owner_vid_q) vid_rdata_d = rdata_sel;
                        else             cpu_rdata_d = rdata_sel;
                    end
                    if (!done) begin
                        terr_d = 1'b1;
                    end
                    state_d = ARB_RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_vid_q <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_rack_q  <= 1'b0;
            cpu_wack_q  <= 1'b0;
            vid_rack_q  <= 1'b0;
            vid_wack_q  <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            streak_q    <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_vid_q <= owner_vid_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rack_q  <= cpu_rack_d;
            cpu_wack_q  <= cpu_wack_d;
            vid_rack_q  <= vid_rack_d;
            vid_wack_q  <= vid_wack_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            streak_q    <= streak_d;
            wd_q        <= wd_d;
        end
    end

    assign cpu_data_read    = cpu_rdata_q;
    assign vid_data_read    = vid_rdata_q;
    assign cpu_read_ack     = cpu_rack_q;
    assign cpu_write_ack    = cpu_wack_q;
    assign vid_read_ack     = vid_rack_q;
    assign vid_write_ack    = vid_wack_q;
    assign cache_address    = addr_q;
    assign cache_data_write = wdata_q;
    assign cache_read_req   = rd_req_q;
    assign cache_write_req  = wr_req_q;
    assign busy             = busy_q;
    assign timeout_err      = terr_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table of single transactions, a behavioural
// cache responder, an ack scoreboard, and hand-written priority and reset sequences.
module tb_cache_arbiter;

    localparam int TIMEOUT = 16;

    logic        sys_clk;
    logic        reset;
    logic [16:0] cpu_address, vid_address, cache_address;
    logic [7:0]  cpu_data_write, vid_data_write, cpu_data_read, vid_data_read;
    logic        cpu_read_req, cpu_write_req, vid_read_req, vid_write_req;
    logic        cpu_read_ack, cpu_write_ack, vid_read_ack, vid_write_ack;
    logic [7:0]  cache_data_write, cache_data_read;
    logic        cache_read_req, cache_write_req, cache_read_ack, cache_write_ack;
    logic        busy, timeout_err;
    logic [3:0]  ackVec;

    cache_arbiter #(.ADDR_W(17), .DATA_W(8), .VID_BURST(4), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_data_write(cpu_data_write),
        .cpu_read_req(cpu_read_req), .cpu_write_req(cpu_write_req),
        .cpu_data_read(cpu_data_read), .cpu_read_ack(cpu_read_ack), .cpu_write_ack(cpu_write_ack),
        .vid_address(vid_address), .vid_data_write(vid_data_write),
        .vid_read_req(vid_read_req), .vid_write_req(vid_write_req),
        .vid_data_read(vid_data_read), .vid_read_ack(vid_read_ack), .vid_write_ack(vid_write_ack),
        .cache_address(cache_address), .cache_data_write(cache_data_write),
        .cache_read_req(cache_read_req), .cache_write_req(cache_write_req),
        .cache_data_read(cache_data_read), .cache_read_ack(cache_read_ack),
        .cache_write_ack(cache_write_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    assign ackVec = {cpu_read_ack, cpu_write_ack, vid_read_ack, vid_write_ack};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          vid;
        bit          rd;
        bit          wr;
        logic [16:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic [7:0]  crdata;
        bit          wrongAck;
        logic [3:0]  expAck;
        int          expCycles;
        logic [7:0]  expData;
        bit          expTerr;
    } vec_t;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] cpuData;
        logic [7:0] vidData;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    logic [7:0] lastCpu = 8'h00;
    logic [7:0] lastVid = 8'h00;
    bit   terrModel = 1'b0;

    int   respLat   = 1;
    logic [7:0] respData = 8'h00;
    bit   respWrong = 1'b0;
    bit   respBusy  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        else passCount++;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " acks"}, {28'd0, ackVec}, 0);
        checkOutput({tag, " cpu_data_read"}, {24'd0, cpu_data_read}, 0);
        checkOutput({tag, " vid_data_read"}, {24'd0, vid_data_read}, 0);
        checkOutput({tag, " cache reqs"}, {30'd0, cache_read_req, cache_write_req}, 0);
        checkOutput({tag, " cache_address"}, {15'd0, cache_address}, 0);
        checkOutput({tag, " cache_data_write"}, {24'd0, cache_data_write}, 0);
        checkOutput({tag, " busy"}, {31'd0, busy}, 0);
        checkOutput({tag, " timeout_err"}, {31'd0, timeout_err}, 0);
    endtask

    // Cache model: answers each request after respLat cycles, optionally with a stray wrong-kind ack first.
    initial begin
        cache_read_ack  = 1'b0;
        cache_write_ack = 1'b0;
        cache_data_read = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (!reset && (cache_read_req || cache_write_req)) begin
                automatic bit isRd = cache_read_req;
                respBusy = 1'b1;
                for (int t = 1; t <= respLat; t++) begin
                    tick();
                    cache_read_ack  = 1'b0;
                    cache_write_ack = 1'b0;
                    if (respWrong && t == 1 && respLat > 2) begin
                        if (isRd) cache_write_ack = 1'b1;
                        else begin
                            cache_read_ack  = 1'b1;
                            cache_data_read = 8'hBB;
                        end
                    end
                    if (t == respLat) begin
                        if (isRd) begin
                            cache_read_ack  = 1'b1;
                            cache_data_read = respData;
                        end else begin
                            cache_write_ack = 1'b1;
                        end
                    end
                end
                tick();
                cache_read_ack  = 1'b0;
                cache_write_ack = 1'b0;
                respBusy = 1'b0;
            end
        end
    end

    // Scoreboard: every requester ack must match the oldest expected completion.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (ackVec != 4'b0000) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected ack", {28'd0, ackVec}, 0);
                end else begin
                    automatic exp_t e = expQ.pop_front();
                    checkOutput("sb ack kind", {28'd0, ackVec}, {28'd0, e.ack});
                    checkOutput("sb cpu_data_read", {24'd0, cpu_data_read}, {24'd0, e.cpuData});
                    checkOutput("sb vid_data_read", {24'd0, vid_data_read}, {24'd0, e.vidData});
                end
            end
        end
    end

    task automatic dropRequests();
        cpu_read_req  = 1'b0;
        cpu_write_req = 1'b0;
        vid_read_req  = 1'b0;
        vid_write_req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int  cyc;
        bit  seen;
        exp_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        cyc = 0;
        while (respBusy && cyc < 100) begin
            tick();
            cyc++;
        end
        respLat   = v.lat;
        respData  = v.crdata;
        respWrong = v.wrongAck;
        if (v.vid) lastVid = v.expData;
        else       lastCpu = v.expData;
        e.ack = v.expAck; e.cpuData = lastCpu; e.vidData = lastVid;
        expQ.push_back(e);
        if (v.vid) begin
            vid_address = v.addr; vid_data_write = v.wdata;
            vid_read_req = v.rd;  vid_write_req = v.wr;
        end else begin
            cpu_address = v.addr; cpu_data_write = v.wdata;
            cpu_read_req = v.rd;  cpu_write_req = v.wr;
        end
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 4 && !seen; i++) begin
            tick();
            if (cache_read_req || cache_write_req) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
        checkOutput({tag, " grant latency"}, cyc, 1);
        if (!seen) begin
            dropRequests();
            return;
        end
        checkOutput({tag, " cache req kind"}, {30'd0, cache_read_req, cache_write_req},
                    v.wr ? 32'd1 : 32'd2);
        checkOutput({tag, " cache_address"}, {15'd0, cache_address}, {15'd0, v.addr});
        checkOutput({tag, " cache_data_write"}, {24'd0, cache_data_write}, {24'd0, v.wdata});
        checkOutput({tag, " timeout_err before"}, {31'd0, timeout_err}, {31'd0, terrModel});
        if (v.vid) begin
            vid_address = ~v.addr; vid_data_write = ~v.wdata;
        end else begin
            cpu_address = ~v.addr; cpu_data_write = ~v.wdata;
        end
        tick();
        checkOutput({tag, " req single pulse"}, {30'd0, cache_read_req, cache_write_req}, 0);
        checkOutput({tag, " address held"}, {15'd0, cache_address}, {15'd0, v.addr});
        checkOutput({tag, " wdata held"}, {24'd0, cache_data_write}, {24'd0, v.wdata});
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            if (ackVec != 4'b0000) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        checkOutput({tag, " ack latency"}, seen ? cyc : 0, v.expCycles);
        terrModel = v.expTerr;
        checkOutput({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, v.expTerr});
        dropRequests();
        tick();
        checkOutput({tag, " ack single pulse"}, {28'd0, ackVec}, 0);
        checkOutput({tag, " busy after release"}, {31'd0, busy}, 0);
    endtask

    vec_t vecs[8];
    vec_t postReset;
    logic [16:0] grantExp[10];

    initial begin
        #100000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int grants, acks;
        bit seen;

        //               vid  rd   wr   addr       wdata  lat crdata wrong  expAck   cyc expData terr
        vecs[0] = '{1'b0, 1'b1, 1'b0, 17'h1ABCD, 8'h00, 3,  8'h5A, 1'b1, 4'b1000, 4,  8'h5A, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 17'h00010, 8'h3C, 2,  8'hEE, 1'b0, 4'b0001, 3,  8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 17'h00123, 8'h77, 1,  8'hEE, 1'b0, 4'b0100, 2,  8'h5A, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 17'h1FFFF, 8'h00, 16, 8'hA5, 1'b0, 4'b0010, 17, 8'hA5, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 17'h0F0F0, 8'hC3, 2,  8'h99, 1'b0, 4'b0001, 3,  8'hA5, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 17'h00ABC, 8'h00, 20, 8'h12, 1'b0, 4'b1000, 17, 8'hFF, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 17'h00000, 8'h00, 4,  8'h00, 1'b1, 4'b0100, 5,  8'hFF, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 17'h00001, 8'h00, 2,  8'h42, 1'b0, 4'b1000, 3,  8'h42, 1'b1};
        postReset = '{1'b1, 1'b1, 1'b0, 17'h00077, 8'h00, 2, 8'h99, 1'b0, 4'b0010, 3, 8'h99, 1'b0};

        reset = 1'b1;
        cpu_address = '0; cpu_data_write = '0;
        vid_address = '0; vid_data_write = '0;
        dropRequests();
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();
        checkOutput("idle busy", {31'd0, busy}, 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        $display("[TB] priority sequence, both requesters held pending");
        cpu_address = 17'h00C00; vid_address = 17'h00D00;
        cpu_data_write = 8'h00;  vid_data_write = 8'h00;
        respLat = 1; respData = 8'h11; respWrong = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_t e;
            if (k == 4 || k == 9) begin
                grantExp[k] = 17'h00C00;
                lastCpu = 8'h11;
                e.ack = 4'b1000;
            end else begin
                grantExp[k] = 17'h00D00;
                lastVid = 8'h11;
                e.ack = 4'b0010;
            end
            e.cpuData = lastCpu; e.vidData = lastVid;
            expQ.push_back(e);
        end
        cpu_read_req = 1'b1;
        vid_read_req = 1'b1;
        grants = 0;
        acks   = 0;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            tick();
            if (cache_read_req) begin
                if (grants < 10)
                    checkOutput($sformatf("grant %0d owner", grants), {15'd0, cache_address},
                                {15'd0, grantExp[grants]});
                grants++;
            end
            if (ackVec != 4'b0000) begin
                acks++;
                if (acks == 10) dropRequests();
            end
        end
        dropRequests();
        checkOutput("priority grant count", grants, 10);
        checkOutput("priority ack count", acks, 10);
        repeat (3) tick();

        $display("[TB] reset during ARB_WAIT");
        respLat = 40; respWrong = 1'b0;
        cpu_address = 17'h1F00F; cpu_data_write = 8'h66; cpu_write_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (cache_write_req) seen = 1'b1;
        end
        checkOutput("reset-test grant", {31'd0, seen}, 1);
        repeat (3) tick();
        checkOutput("busy in wait", {31'd0, busy}, 1);
        reset = 1'b1;
        cpu_write_req = 1'b0;
        tick();
        checkResetValues("mid-reset");
        reset = 1'b0;
        lastCpu = 8'h00; lastVid = 8'h00; terrModel = 1'b0;
        repeat (45) tick();
        applyStimulus(postReset, 8);

        repeat (3) tick();
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
